// File: rtl/ft245_fifo_ifc.sv
// FT245 async FIFO bus master with RX/TX byte FIFOs and a strobe-timing FSM.
// Define FT245_SIWU_EN to pulse siwu on the first TX_HOLD cycle when TX drains.
module ft245_fifo_ifc #(
   parameter int RX_AW      = 4,
   parameter int TX_AW      = 4,
   parameter int STROBE_CYC = 1,
   parameter int HOLD_CYC   = 2
) (
   input  logic             clk,
   input  logic             reset,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [RX_AW:0]   rx_level,
   output logic [TX_AW:0]   tx_level,
   input  logic [7:0]       data_in,
   output logic [7:0]       data_out,
   output logic             dir_out,
   input  logic             rxf,
   input  logic             txe,
   output logic             rd,
   output logic             wr,
   output logic             siwu
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] TX_SETUP  = 3'd1;
   localparam logic [2:0] TX_STROBE = 3'd2;
   localparam logic [2:0] TX_HOLD   = 3'd3;
   localparam logic [2:0] RX_STROBE = 3'd4;
   localparam logic [2:0] RX_HOLD   = 3'd5;

   localparam logic [RX_AW:0]   RX_FULL = {1'b1, {RX_AW{1'b0}}};
   localparam logic [TX_AW:0]   TX_FULL = {1'b1, {TX_AW{1'b0}}};
   localparam logic [RX_AW:0]   RX_L1   = 1;
   localparam logic [TX_AW:0]   TX_L1   = 1;
   localparam logic [RX_AW-1:0] RX_P1   = 1;
   localparam logic [TX_AW-1:0] TX_P1   = 1;
   localparam logic [3:0]       S_LAST  = 4'(STROBE_CYC - 1);
   localparam logic [3:0]       H_LAST  = 4'(HOLD_CYC - 1);

   logic [2:0]       state;
   logic [3:0]       cnt;
   logic             last_rx;
   logic             rxf_meta, rxf_sync;
   logic             txe_meta, txe_sync;
   logic [7:0]       rx_mem [0:(1<<RX_AW)-1];
   logic [7:0]       tx_mem [0:(1<<TX_AW)-1];
   logic [RX_AW-1:0] rx_wp, rx_rp;
   logic [TX_AW-1:0] tx_wp, tx_rp;
   logic             tx_pend, rx_pend, go_tx, go_rx;
   logic             rx_push, rx_pop, tx_push, tx_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         rxf_meta <= 1'b0;
         rxf_sync <= 1'b0;
         txe_meta <= 1'b0;
         txe_sync <= 1'b0;
      end else begin
         rxf_meta <= rxf;
         rxf_sync <= rxf_meta;
         txe_meta <= txe;
         txe_sync <= txe_meta;
      end
   end

   assign tx_pend = (tx_level != '0) && txe_sync;
   assign rx_pend = rxf_sync && (rx_level != RX_FULL);
   // last_rx set means RX was serviced last, so TX wins a tie
   assign go_tx   = (state == IDLE) && tx_pend && (!rx_pend || last_rx);
   assign go_rx   = (state == IDLE) && rx_pend && !go_tx;
   assign rx_push = (state == RX_STROBE) && (cnt == S_LAST);
   assign rx_pop  = rx_valid && rx_ready;
   assign tx_push = tx_valid && tx_ready;
   assign tx_pop  = go_tx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         last_rx  <= 1'b1;
         data_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (go_tx) begin
                  state    <= TX_SETUP;
                  data_out <= tx_mem[tx_rp];
                  last_rx  <= 1'b0;
               end else if (go_rx) begin
                  state   <= RX_STROBE;
                  last_rx <= 1'b1;
               end
            end
            TX_SETUP: state <= TX_STROBE;
            TX_STROBE: begin
               if (cnt == S_LAST) begin
                  state <= TX_HOLD;
                  cnt   <= '0;
               end else cnt <= cnt + 4'd1;
            end
            TX_HOLD: begin
               if (cnt == H_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else cnt <= cnt + 4'd1;
            end
            RX_STROBE: begin
               if (cnt == S_LAST) begin
                  state <= RX_HOLD;
                  cnt   <= '0;
               end else cnt <= cnt + 4'd1;
            end
            RX_HOLD: begin
               if (cnt == H_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else cnt <= cnt + 4'd1;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign wr      = (state == TX_STROBE);
   assign rd      = (state == RX_STROBE);
   assign dir_out = (state == TX_SETUP) || (state == TX_STROBE) ||
                    ((state == TX_HOLD) && (cnt == 4'd0));

`ifdef FT245_SIWU_EN
   assign siwu = (state == TX_HOLD) && (cnt == 4'd0) && (tx_level == '0);
`else
   assign siwu = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= data_in;
      if (tx_push) tx_mem[tx_wp] <= tx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_wp    <= '0;
         rx_rp    <= '0;
         rx_level <= '0;
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_level <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + RX_P1;
         if (rx_pop)  rx_rp <= rx_rp + RX_P1;
         if (tx_push) tx_wp <= tx_wp + TX_P1;
         if (tx_pop)  tx_rp <= tx_rp + TX_P1;
         case ({rx_push, rx_pop})
            2'b10:   rx_level <= rx_level + RX_L1;
            2'b01:   rx_level <= rx_level - RX_L1;
            default: rx_level <= rx_level;
         endcase
         case ({tx_push, tx_pop})
            2'b10:   tx_level <= tx_level + TX_L1;
            2'b01:   tx_level <= tx_level - TX_L1;
            default: tx_level <= tx_level;
         endcase
      end
   end

   assign rx_data  = rx_mem[rx_rp];
   assign rx_valid = (rx_level != '0);
   assign tx_ready = (tx_level != TX_FULL);

endmodule

// File: tb/tb_ft245_fifo_ifc.sv
// Bench for ft245_fifo_ifc: two instances (fast and slow strobe timing)
// checked every cycle against a queue/offset model plus literal scenarios.
`timescale 1ns/1ps
module tb_ft245_fifo_ifc;

   localparam int RXD = 4;
   localparam int TXD = 16;
`ifdef FT245_SIWU_EN
   localparam bit SIWU = 1'b1;
`else
   localparam bit SIWU = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] data_in = 8'h00;
   logic       tx_valid = 1'b0;
   logic       rx_ready = 1'b0;
   logic       rxf = 1'b0;
   logic       txe = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : m
      localparam int SC = (g == 0) ? 1 : 3;
      localparam int HC = (g == 0) ? 2 : 4;
      logic [7:0] rx_data_w, data_out_w;
      logic       rx_valid_w, tx_ready_w, dir_w, rd_w, wr_w, siwu_w;
      logic [2:0] rx_level_w;
      logic [4:0] tx_level_w;

      ft245_fifo_ifc #(
         .RX_AW(2), .TX_AW(4), .STROBE_CYC(SC), .HOLD_CYC(HC)
      ) u_dut (
         .clk(clk), .reset(reset),
         .rx_data(rx_data_w), .rx_valid(rx_valid_w), .rx_ready(rx_ready),
         .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_w),
         .rx_level(rx_level_w), .tx_level(tx_level_w),
         .data_in(data_in), .data_out(data_out_w), .dir_out(dir_w),
         .rxf(rxf), .txe(txe), .rd(rd_w), .wr(wr_w), .siwu(siwu_w)
      );

      // model: byte queues plus the offset k into the current bus operation
      logic [7:0] txq [$];
      logic [7:0] rxq [$];
      int         op = 0;
      int         k = 0;
      bit         last_rx, rxf_m, rxf_s, txe_m, txe_s;
      bit         live = 1'b0;
      logic [7:0] dout;

      always @(posedge clk) begin
         bit tp, rp, pu, po;
         if (reset) begin
            txq.delete();
            rxq.delete();
            op = 0; k = 0; last_rx = 1'b1; dout = 8'h00;
            rxf_m = 0; rxf_s = 0; txe_m = 0; txe_s = 0;
            live = 1'b1;
         end else if (live) begin
            pu = tx_valid && (txq.size() != TXD);
            po = rx_ready && (rxq.size() != 0);
            tp = (txq.size() != 0) && txe_s;
            rp = rxf_s && (rxq.size() != RXD);
            if (po) void'(rxq.pop_front());
            if (op == 0) begin
               if (tp && (!rp || last_rx)) begin
                  dout = txq.pop_front();
                  op = 1; k = 0; last_rx = 1'b0;
               end else if (rp) begin
                  op = 2; k = 0; last_rx = 1'b1;
               end
            end else begin
               if (op == 2 && k == SC - 1) rxq.push_back(data_in);
               if (k == ((op == 1) ? SC + HC : SC + HC - 1)) op = 0;
               else k++;
            end
            if (pu) txq.push_back(tx_data);
            txe_s = txe_m; txe_m = txe;
            rxf_s = rxf_m; rxf_m = rxf;
         end
      end

      always @(negedge clk) begin
         bit ewr, erd, edir, esw;
         if (live) begin
            ewr  = (op == 1) && (k >= 1) && (k <= SC);
            erd  = (op == 2) && (k < SC);
            edir = (op == 1) && (k <= SC + 1);
            esw  = SIWU && (op == 1) && (k == SC + 1) && (txq.size() == 0);
            chk($sformatf("m%0d.rx_level", g), 32'(rx_level_w), 32'(rxq.size()));
            chk($sformatf("m%0d.tx_level", g), 32'(tx_level_w), 32'(txq.size()));
            chk($sformatf("m%0d.rx_valid", g), 32'(rx_valid_w), 32'(rxq.size() != 0));
            chk($sformatf("m%0d.tx_ready", g), 32'(tx_ready_w), 32'(txq.size() != TXD));
            if (rxq.size() != 0)
               chk($sformatf("m%0d.rx_data", g), 32'(rx_data_w), 32'(rxq[0]));
            chk($sformatf("m%0d.data_out", g), 32'(data_out_w), 32'(dout));
            chk($sformatf("m%0d.wr", g), 32'(wr_w), 32'(ewr));
            chk($sformatf("m%0d.rd", g), 32'(rd_w), 32'(erd));
            chk($sformatf("m%0d.dir_out", g), 32'(dir_w), 32'(edir));
            chk($sformatf("m%0d.siwu", g), 32'(siwu_w), 32'(esw));
         end
      end
   end

   int n_rd0, w1, maxw, minw, gap, ming;
   bit prev0, prev1, seen, pw, pr, found;
   int ev [$];

   initial begin
      // reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst.rx_valid", 32'(m[0].rx_valid_w), 32'd0);
      chk("rst.tx_ready", 32'(m[0].tx_ready_w), 32'd1);
      chk("rst.tx_level", 32'(m[0].tx_level_w), 32'd0);
      chk("rst.data_out", 32'(m[0].data_out_w), 32'd0);
      chk("rst.strobes", 32'({m[0].rd_w, m[0].wr_w, m[0].dir_w, m[0].siwu_w}), 32'd0);

      // single TX byte 0xA5: wr in cycle 3, dir_out cycles 2..4
      txe = 1'b1;
      repeat (4) @(posedge clk);
      #1 tx_valid = 1'b1; tx_data = 8'hA5;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("a5.wr.c%0d", c), 32'(m[0].wr_w), 32'(c == 3));
         chk($sformatf("a5.dir.c%0d", c), 32'(m[0].dir_w), 32'(c >= 2 && c <= 4));
         chk($sformatf("a5.siwu.c%0d", c), 32'(m[0].siwu_w), 32'(SIWU && c == 4));
         if (c == 3) chk("a5.data_out", 32'(m[0].data_out_w), 32'h0A5);
      end
      repeat (15) @(posedge clk);

      // RX fill with rx_ready low: 4 rd pulses then none
      #1 data_in = 8'h3C; rxf = 1'b1; rx_ready = 1'b0;
      n_rd0 = 0; prev0 = 0; prev1 = 0; w1 = 0; maxw = 0; minw = 99;
      gap = 0; ming = 99; seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (m[0].rd_w && !prev0) n_rd0++;
         prev0 = m[0].rd_w;
         if (m[1].rd_w) begin
            w1++;
            if (!prev1 && seen && gap < ming) ming = gap;
         end else begin
            if (prev1) begin
               if (w1 > maxw) maxw = w1;
               if (w1 < minw) minw = w1;
               w1 = 0; seen = 1; gap = 0;
            end
            gap++;
         end
         prev1 = m[1].rd_w;
      end
      chk("fill.rd_pulses", 32'(n_rd0), 32'd4);
      chk("fill.rx_level", 32'(m[0].rx_level_w), 32'd4);
      chk("fill.rx_data", 32'(m[0].rx_data_w), 32'h03C);
      chk("slow.rx_level", 32'(m[1].rx_level_w), 32'd4);
      chk("slow.rd_wmax", 32'(maxw), 32'd3);
      chk("slow.rd_wmin", 32'(minw), 32'd3);
      chk("slow.gap_ge4", 32'(ming >= 4 && ming < 99), 32'd1);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      n_rd0 = 0; prev0 = 0;
      repeat (10) begin
         @(negedge clk);
         if (m[0].rd_w && !prev0) n_rd0++;
         prev0 = m[0].rd_w;
      end
      chk("pop.rd_resume", 32'(n_rd0), 32'd1);
      #1 rxf = 1'b0; rx_ready = 1'b1;
      repeat (30) @(posedge clk);
      chk("drain.rx_level", 32'(m[0].rx_level_w), 32'd0);

      // tie between TX and RX after reset: wr first, then alternate
      #1 reset = 1'b1; txe = 1'b0; rxf = 1'b0; data_in = 8'h5A;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tx_valid = 1'b1;
         tx_data = 8'(8'h11 * (i + 1));
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
      txe = 1'b1; rxf = 1'b1;
      ev.delete(); pw = 0; pr = 0;
      for (int i = 0; i < 100 && ev.size() < 6; i++) begin
         @(negedge clk);
         if (m[0].wr_w && !pw) ev.push_back(1);
         if (m[0].rd_w && !pr) ev.push_back(2);
         pw = m[0].wr_w; pr = m[0].rd_w;
      end
      chk("alt.count", 32'(ev.size()), 32'd6);
      for (int i = 0; i < 6 && i < ev.size(); i++)
         chk($sformatf("alt.ev%0d", i), 32'(ev[i]), 32'((i % 2 == 0) ? 1 : 2));
      #1 rxf = 1'b0;
      repeat (30) @(posedge clk);

      // reset during TX_STROBE
      #1 tx_valid = 1'b1; tx_data = 8'hC3;
      @(posedge clk);
      #1 tx_data = 8'h7E;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (m[0].wr_w) found = 1;
      end
      chk("rstmid.wr_seen", 32'(found), 32'd1);
      chk("rstmid.lvl_before", 32'(m[0].tx_level_w), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid.wr", 32'(m[0].wr_w), 32'd0);
      chk("rstmid.tx_level", 32'(m[0].tx_level_w), 32'd0);
      chk("rstmid.tx_ready", 32'(m[0].tx_ready_w), 32'd1);
      reset = 1'b0;
      repeat (10) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ft245_fifo_ifc.md
FT245_FIFO_IFC -- requirements
Module: ft245_fifo_ifc

Interface
REQ-001 SHALL have parameter RX_AW, default 4, meaning RX FIFO depth 2^RX_AW bytes (legal 1..8).
REQ-002 SHALL have parameter TX_AW, default 4, meaning TX FIFO depth 2^TX_AW bytes (legal 1..8).
REQ-003 SHALL have parameter STROBE_CYC, default 1, meaning rd/wr pulse width in clk cycles (legal 1..15).
REQ-004 SHALL have parameter HOLD_CYC, default 2, meaning recovery cycles after each strobe (legal 2..15).
REQ-005 SHALL have port clk, in, 1: clock; all logic is clocked on the rising edge.
REQ-006 SHALL have port reset, in, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports rx_data out 8 / rx_valid out 1 / rx_ready in 1: RX FIFO head byte, valid/ready pop side.
REQ-008 SHALL have ports tx_data in 8 / tx_valid in 1 / tx_ready out 1: TX FIFO valid/ready push side.
REQ-009 SHALL have ports rx_level out RX_AW+1 / tx_level out TX_AW+1: current FIFO occupancy.
REQ-010 SHALL have ports data_in in 8 / data_out out 8 / dir_out out 1: FT245 bus sample, drive value and drive enable.
REQ-011 SHALL have ports rxf in 1 (byte available) / txe in 1 (space available), both active-high and asynchronous.
REQ-012 SHALL have ports rd out 1 / wr out 1 / siwu out 1: FT245 strobes, all active-high.

Function
REQ-013 SHALL pass rxf and txe each through a 2-flop synchroniser; the FSM uses only the synchronised values.
REQ-014 SHALL use a first-word-fall-through RX FIFO: rx_valid = (rx_level != 0); rx_data = head byte; a pop occurs when rx_valid && rx_ready.
REQ-015 SHALL hold tx_ready = (tx_level != 2^TX_AW); a push occurs when tx_valid && tx_ready.
REQ-016 SHALL count a simultaneous push and pop on one FIFO as no net level change; pointers wrap modulo depth.
REQ-017 SHALL implement the FSM states IDLE, TX_SETUP, TX_STROBE, TX_HOLD, RX_STROBE and RX_HOLD.
REQ-018 SHALL define tx_pend = (tx_level != 0) && txe_sync, evaluated in IDLE.
REQ-019 SHALL define rx_pend = rxf_sync && (rx_level != 2^RX_AW), evaluated in IDLE.
REQ-020 SHALL resolve simultaneous tx_pend and rx_pend in favour of the direction not serviced last (round-robin via last_dir register); a single pending direction always wins.
REQ-021 SHALL, on IDLE->TX_SETUP, pop the TX head into the data_out register; data_out stays stable until the next TX_SETUP.
REQ-022 SHALL hold TX_SETUP for 1 cycle with dir_out=1 and wr=0.
REQ-023 SHALL hold TX_STROBE for STROBE_CYC cycles with dir_out=1 and wr=1.
REQ-024 SHALL hold TX_HOLD for HOLD_CYC cycles, with dir_out=1 on the first cycle only and wr=0.
REQ-025 SHALL hold RX_STROBE for STROBE_CYC cycles with rd=1 and dir_out=0.
REQ-026 SHALL push data_in into the RX FIFO at the end of the last RX_STROBE cycle.
REQ-027 SHALL hold RX_HOLD for HOLD_CYC cycles with rd=0, then return to IDLE.
REQ-028 SHALL never assert rd and wr, or rd and dir_out, in the same cycle.
REQ-029 SHALL assert wr in cycle 3 when a push into an empty TX FIFO occurs in cycle 0 while the FSM is IDLE and txe_sync=1.
REQ-030 SHALL assert rx_valid in the cycle after the last RX_STROBE cycle when the RX FIFO was empty.
REQ-031 SHALL not start an RX transfer when the RX FIFO is full, so no RX byte is ever dropped.

Reset
REQ-032 SHALL, on reset, set state=IDLE, empty both FIFOs and set rx_level=tx_level=0.
REQ-033 SHALL, on reset, set rx_valid=0, tx_ready=1, rd=wr=dir_out=siwu=0, data_out=0, synchronisers=0, and last_dir=RX (TX wins the first tie).
REQ-034 SHALL, on reset mid-transfer, deassert rd/wr the next cycle; the partial RX byte and the already-popped TX byte are discarded.

Configuration
REQ-035 SHALL, with FT245_SIWU_EN defined, assert siwu for exactly the first TX_HOLD cycle when tx_level==0 at that cycle (send-immediate on drain).
REQ-036 SHALL, with FT245_SIWU_EN undefined, tie siwu to 0 and remove the associated logic.

Verification
REQ-037 SHALL cover: txe=1, push 0xA5 into empty TX (defaults) -> wr high for 1 cycle in cycle 3, data_out=0xA5, dir_out high in cycles 2-4.
REQ-038 SHALL cover: rxf=1, data_in=0x3C, rx_ready=0 with RX_AW=2 -> exactly 4 rd pulses, rx_level=4, then rd stays 0 until a pop.
REQ-039 SHALL cover: rxf=txe=1 with TX FIFO holding 3 bytes -> strobes alternate wr,rd,wr,rd...; wr is first after reset.
REQ-040 SHALL cover: STROBE_CYC=3, HOLD_CYC=4 -> rd is 3 cycles wide and the gap to the next strobe is >=4 cycles.
REQ-041 SHALL cover: reset asserted during TX_STROBE -> wr=0 the next cycle, tx_level=0, tx_ready=1.
REQ-042 SHALL cover: FT245_SIWU_EN defined, single TX byte -> siwu=1 for one cycle in the first TX_HOLD cycle; undefined -> siwu=0 throughout.
